// File: rtl/wbarb.sv
// Writeback arbiter: one-entry hold buffer per execute unit, round-robin grant
// onto a single registered writeback bus, with flush and async reset.
module wbarb #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_error,
  input  logic [7*N_REQ-1:0]   req_robid,
  input  logic [6*N_REQ-1:0]   req_rd,
  input  logic [32*N_REQ-1:0]  req_result,
  output logic [N_REQ-1:0]     wbarb_stall,
  input  logic                 rob_flush,
  output logic                 wb_valid,
  output logic                 wb_error,
  output logic [6:0]           wb_robid,
  output logic [5:0]           wb_rd,
  output logic [31:0]          wb_result
);

  localparam int unsigned ROB_W  = 7;
  localparam int unsigned RD_W   = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SCAN_W = PTR_W + 1;

  typedef struct packed {
    logic              error;
    logic [ROB_W-1:0]  robid;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
  } wb_entry_t;

  wb_entry_t          req_entry  [N_REQ];
  wb_entry_t          hold_entry [N_REQ];
  logic [N_REQ-1:0]   hold_valid;
  logic [PTR_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [SCAN_W-1:0]  scan_idx;
  logic [N_REQ-1:0]   accept;

  // Slice the flat request buses into per-unit entries
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_entry[i].error  = req_error[i];
      req_entry[i].robid  = req_robid[ROB_W*i +: ROB_W];
      req_entry[i].rd     = req_rd[RD_W*i +: RD_W];
      req_entry[i].result = req_result[DATA_W*i +: DATA_W];
    end
  end

  // Round-robin search upward from rr_ptr, wrapping at N_REQ-1
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = SCAN_W'(rr_ptr) + SCAN_W'(k);
      if (scan_idx >= SCAN_W'(N_REQ)) begin
        scan_idx = scan_idx - SCAN_W'(N_REQ);
      end
      if (!grant_any && hold_valid[scan_idx[PTR_W-1:0]]) begin
        grant_any                   = 1'b1;
        grant_idx                   = scan_idx[PTR_W-1:0];
        grant[scan_idx[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  // A granted unit drains this cycle, so it can take a new entry
  always_comb begin
    wbarb_stall = '0;
    if (rst && !rob_flush) begin
      wbarb_stall = hold_valid & ~grant;
    end
    accept = rob_flush ? '0 : (req_valid & ~wbarb_stall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      wb_valid   <= 1'b0;
      wb_error   <= 1'b0;
      wb_robid   <= '0;
      wb_rd      <= '0;
      wb_result  <= '0;
    end else if (rob_flush) begin
      hold_valid <= '0;
      wb_valid   <= 1'b0;
    end else begin
      wb_valid   <= grant_any;
      hold_valid <= (hold_valid & ~grant) | accept;
      if (grant_any) begin
        wb_error  <= hold_entry[grant_idx].error;
        wb_robid  <= hold_entry[grant_idx].robid;
        wb_rd     <= hold_entry[grant_idx].rd;
        wb_result <= hold_entry[grant_idx].result;
        rr_ptr    <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  // Payload storage is qualified by hold_valid, so it needs no reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        hold_entry[i] <= req_entry[i];
      end
    end
  end

endmodule

// File: tb/tb_wbarb.sv
// Randomised and directed bench for wbarb against a queue-free transaction model
// of the hold buffers, round-robin pointer and writeback register.
module tb_wbarb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_error;
  logic [27:0]   req_robid;
  logic [23:0]   req_rd;
  logic [127:0]  req_result;
  logic [3:0]    wbarb_stall;
  logic          rob_flush;
  logic          wb_valid;
  logic          wb_error;
  logic [6:0]    wb_robid;
  logic [5:0]    wb_rd;
  logic [31:0]   wb_result;

  wbarb #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_error  (req_error),
    .req_robid  (req_robid),
    .req_rd     (req_rd),
    .req_result (req_result),
    .wbarb_stall(wbarb_stall),
    .rob_flush  (rob_flush),
    .wb_valid   (wb_valid),
    .wb_error   (wb_error),
    .wb_robid   (wb_robid),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        err;
    bit [6:0]  robid;
    bit [5:0]  rd;
    bit [31:0] res;
  } ent_t;

  ent_t m_hold [N];
  bit   m_hv   [N];
  ent_t m_wb;
  bit   m_wbv;
  int   m_rr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i]   = 1'b0;
      m_hold[i] = '{default: 0};
    end
    m_wb  = '{default: 0};
    m_wbv = 1'b0;
    m_rr  = 0;
  endfunction

  // First held unit found scanning upward from the pointer, modulo N
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (m_hv[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_req();
    req_valid  = '0;
    req_error  = '0;
    req_robid  = '0;
    req_rd     = '0;
    req_result = '0;
  endtask

  task automatic put(input int u, input logic [6:0] robid, input logic [5:0] rd,
                     input logic [31:0] res, input logic err);
    req_valid[u]          = 1'b1;
    req_error[u]          = err;
    req_robid[7*u +: 7]   = robid;
    req_rd[6*u +: 6]      = rd;
    req_result[32*u +: 32] = res;
  endtask

  // One clock: check stalls, advance model, take the edge, check writeback
  task automatic step(input logic fl);
    int g;
    bit exp_st [N];
    rob_flush = fl;
    #1;
    g = model_grant();
    for (int i = 0; i < N; i++) begin
      exp_st[i] = !fl && m_hv[i] && (i != g);
      check($sformatf("stall%0d", i), 32'(wbarb_stall[i]), 32'(exp_st[i]));
    end
    if (fl) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_wbv = 1'b0;
    end else begin
      if (g >= 0) begin
        m_wbv   = 1'b1;
        m_wb    = m_hold[g];
        m_hv[g] = 1'b0;
        m_rr    = (g + 1) % N;
      end else begin
        m_wbv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !exp_st[i]) begin
          m_hv[i]         = 1'b1;
          m_hold[i].err   = req_error[i];
          m_hold[i].robid = req_robid[7*i +: 7];
          m_hold[i].rd    = req_rd[6*i +: 6];
          m_hold[i].res   = req_result[32*i +: 32];
        end
      end
    end
    @(posedge clk);
    #1;
    check("wb_valid",  32'(wb_valid),  32'(m_wbv));
    check("wb_error",  32'(wb_error),  32'(m_wb.err));
    check("wb_robid",  32'(wb_robid),  32'(m_wb.robid));
    check("wb_rd",     32'(wb_rd),     32'(m_wb.rd));
    check("wb_result", wb_result,      m_wb.res);
    clear_req();
    rob_flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(wb_valid),    32'd0);
    check({tag, "_error"},  32'(wb_error),    32'd0);
    check({tag, "_robid"},  32'(wb_robid),    32'd0);
    check({tag, "_rd"},     32'(wb_rd),       32'd0);
    check({tag, "_result"}, wb_result,        32'd0);
    check({tag, "_stall"},  32'(wbarb_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    rob_flush = 1'b0;
    clear_req();
    model_reset();
    #3;
    check_all_zero("reset");
    #9 rst = 1'b1;

    // Contention from rr_ptr=0: robids 1..4 in unit order
    for (int u = 0; u < N; u++) put(u, 7'(u + 1), 6'(u + 8), 32'h1000 + 32'(u), 1'b0);
    step(1'b0);
    check("cont_lat", 32'(wb_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0);
      check("cont_robid", 32'(wb_robid), 32'(k));
    end
    step(1'b0);
    check("cont_idle", 32'(wb_valid), 32'd0);

    // Single request on unit 2, two-cycle latency
    put(2, 7'h15, 6'h03, 32'hDEADBEEF, 1'b1);
    step(1'b0);
    check("single_lat", 32'(wb_valid), 32'd0);
    step(1'b0);
    check("single_valid",  32'(wb_valid),  32'd1);
    check("single_robid",  32'(wb_robid),  32'h15);
    check("single_rd",     32'(wb_rd),     32'h03);
    check("single_result", wb_result,      32'hDEADBEEF);
    check("single_error",  32'(wb_error),  32'd1);

    // Pointer now 3: units 0 and 3 -> 3 first, then wrap to 0
    put(0, 7'h30, 6'h10, 32'hA0, 1'b0);
    put(3, 7'h33, 6'h13, 32'hA3, 1'b0);
    step(1'b0);
    step(1'b0);
    check("wrap_first", 32'(wb_robid), 32'h33);
    step(1'b0);
    check("wrap_second", 32'(wb_robid), 32'h30);
    // Pointer should be 1: unit 1 beats unit 2
    put(1, 7'h41, 6'h01, 32'hB1, 1'b0);
    put(2, 7'h42, 6'h02, 32'hB2, 1'b0);
    step(1'b0);
    step(1'b0);
    check("rr_after_wrap", 32'(wb_robid), 32'h41);
    step(1'b0);
    check("rr_next", 32'(wb_robid), 32'h42);

    // Back-to-back on unit 1
    for (int k = 0; k < 6; k++) begin
      if (k < 5) put(1, 7'(8'h50 + k), 6'(k), 32'hC000 + 32'(k), 1'b0);
      step(1'b0);
      if (k > 0) begin
        check("b2b_valid", 32'(wb_valid), 32'd1);
        check("b2b_robid", 32'(wb_robid), 32'h50 + 32'(k - 1));
      end
    end

    // Flush discards held entries
    put(0, 7'h60, 6'h20, 32'hD0, 1'b0);
    put(1, 7'h61, 6'h21, 32'hD1, 1'b0);
    step(1'b0);
    step(1'b1);
    check("flush_wbv", 32'(wb_valid), 32'd0);
    step(1'b0);
    check("flush_after", 32'(wb_valid), 32'd0);
    put(2, 7'h62, 6'h22, 32'hD2, 1'b0);
    step(1'b0);
    step(1'b0);
    check("flush_new_valid", 32'(wb_valid), 32'd1);
    check("flush_new_robid", 32'(wb_robid), 32'h62);

    // Async reset between edges with three entries held
    put(0, 7'h70, 6'h30, 32'hE0, 1'b1);
    put(1, 7'h71, 6'h31, 32'hE1, 1'b0);
    put(2, 7'h72, 6'h32, 32'hE2, 1'b0);
    step(1'b0);
    step(1'b0);
    check("pre_rst_valid", 32'(wb_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2 rst = 1'b1;
    step(1'b0);
    check("post_rst_idle0", 32'(wb_valid), 32'd0);
    step(1'b0);
    check("post_rst_idle1", 32'(wb_valid), 32'd0);
    put(3, 7'h73, 6'h33, 32'hF3, 1'b0);
    put(0, 7'h74, 6'h34, 32'hF0, 1'b0);
    step(1'b0);
    step(1'b0);
    check("post_rst_first", 32'(wb_robid), 32'h74);
    step(1'b0);
    check("post_rst_second", 32'(wb_robid), 32'h73);

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < N; u++) begin
        if ($urandom_range(1, 0) == 1)
          put(u, 7'($urandom), 6'($urandom), $urandom, 1'($urandom));
      end
      step(($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
